// File: rtl/tx_burst_driver_if.sv
// Handshake bundle between the pulse generator and the H-bridge gate-drive stage.
// The master side is the pulse generator; the slave side is the burst driver.
interface tx_burst_driver_if;
  logic in;
  logic in_en;
  logic fault_clear;
  logic drv_p;
  logic drv_n;
  logic drv_en;
  logic fault;
  logic burst_dropped;

  modport master (
    output in, in_en, fault_clear,
    input  drv_p, drv_n, drv_en, fault, burst_dropped
  );

  modport slave (
    input  in, in_en, fault_clear,
    output drv_p, drv_n, drv_en, fault, burst_dropped
  );
endinterface

// File: rtl/tx_burst_driver.sv
// Complementary, dead-time-protected H-bridge gate drive with a burst-length limit,
// a latching over-length fault and an enforced idle gap between bursts.
module tx_burst_driver #(
  parameter int DEAD_CYCLES       = 1,
  parameter int MAX_ACTIVE_CYCLES = 128,
  parameter int MIN_IDLE_CYCLES   = 81
) (
  input  logic               clk,
  input  logic               n_reset,
  tx_burst_driver_if.slave   bus
);

  localparam int ACT_W  = $clog2(MAX_ACTIVE_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int IDLE_W = $clog2(MIN_IDLE_CYCLES + 1);

  localparam logic [ACT_W-1:0]  ACT_MAX   = ACT_W'(MAX_ACTIVE_CYCLES);
  localparam logic [ACT_W-1:0]  ACT_LAST  = ACT_W'(MAX_ACTIVE_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(MIN_IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ON_P,
    ON_N,
    DEAD,
    COOLDOWN,
    FAULT
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [ACT_W-1:0]   act_cnt;
  logic [DEAD_W-1:0]  dead_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               ending;
  logic               in_en_q;
  logic               act_hit;

  // The next active cycle would exceed the burst limit while the burst is still requested.
  assign act_hit = (act_cnt == ACT_LAST) && bus.in_en;

  always_comb begin
    // NOTE: default first so every path assigns nxt and no latch is inferred.
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.in_en) nxt = bus.in ? ON_P : ON_N;
      end
      ON_P: begin
        if (act_hit)                     nxt = FAULT;
        else if (!bus.in_en || !bus.in)  nxt = DEAD;
      end
      ON_N: begin
        if (act_hit)                     nxt = FAULT;
        else if (!bus.in_en || bus.in)   nxt = DEAD;
      end
      DEAD: begin
        if (act_hit) begin
          nxt = FAULT;
        end else if (dead_cnt == DEAD_LAST) begin
          if (ending || !bus.in_en) nxt = COOLDOWN;
          else                      nxt = bus.in ? ON_P : ON_N;
        end
      end
      COOLDOWN: begin
        if (idle_cnt == IDLE_LAST) nxt = IDLE;
      end
      FAULT: begin
        if (bus.fault_clear && !bus.in_en) nxt = COOLDOWN;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state             <= IDLE;
      act_cnt           <= '0;
      dead_cnt          <= '0;
      idle_cnt          <= '0;
      ending            <= 1'b0;
      in_en_q           <= 1'b0;
      bus.drv_p         <= 1'b0;
      bus.drv_n         <= 1'b0;
      bus.drv_en        <= 1'b0;
      bus.fault         <= 1'b0;
      bus.burst_dropped <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values.
      state   <= nxt;
      in_en_q <= bus.in_en;

      if (state == IDLE)
        act_cnt <= '0;
      else if ((state inside {ON_P, ON_N, DEAD}) && (act_cnt != ACT_MAX))
        act_cnt <= act_cnt + 1'b1;

      if (state != DEAD)
        dead_cnt <= '0;
      else if (dead_cnt != DEAD_LAST)
        dead_cnt <= dead_cnt + 1'b1;

      if (state != COOLDOWN)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_LAST)
        idle_cnt <= idle_cnt + 1'b1;

      // Remember whether DEAD was entered because the burst ended.
      if (state inside {ON_P, ON_N})
        ending <= !bus.in_en;

      bus.drv_p         <= (nxt == ON_P);
      bus.drv_n         <= (nxt == ON_N);
      bus.drv_en        <= (nxt inside {ON_P, ON_N, DEAD});
      bus.fault         <= (nxt == FAULT);
      bus.burst_dropped <= bus.in_en && !in_en_q && (state inside {COOLDOWN, FAULT});
    end
  end

endmodule

// File: doc/tx_burst_driver.md
Name: tx_burst_driver

Overview:
Output stage directly downstream of the delay line's pulse generator. It consumes the single-ended modulated pulse train (out) and its burst-active qualifier (out_en), and produces complementary, dead-time-protected gate drives for the transducer H-bridge. It enforces a maximum burst length, with a latching fault, and a minimum idle gap between bursts. Bursts that arrive while the stage is blocked are reported.

Parameters:
DEAD_CYCLES, 1, clk cycles with both drives low between any phase change; legal range is 1 or more.
MAX_ACTIVE_CYCLES, 128, maximum consecutive cycles drv_en may be high before a fault.
MIN_IDLE_CYCLES, 81, cycles in COOLDOWN after every burst or fault clear (1 us at 81 MHz).

Ports:
clk  in  1  system clock, 81 MHz
n_reset  in  1  synchronous, active-low reset
in  in  1  modulated pulse train from pulse generator; synchronous to clk
in_en  in  1  burst-active qualifier from pulse generator
fault_clear  in  1  level; releases the FAULT state
drv_p  out  1  high-side/positive phase gate drive
drv_n  out  1  negative phase gate drive
drv_en  out  1  bridge enable; high for the whole burst, including dead time
fault  out  1  sticky over-length fault
burst_dropped  out  1  one-cycle pulse when a burst is rejected

Behaviour:
- Clock and reset: clk; n_reset is synchronous and active-low. All outputs are registered. On reset, all outputs are 0 and the state is IDLE; this holds even mid-burst, with drives low on the first reset edge.
- Inputs are already clk-synchronous, so the block adds no synchroniser stages. Latency from an input sample to the drive change is 1 cycle.
- States: IDLE, ON_P, ON_N, DEAD, COOLDOWN, FAULT.
- IDLE: all drives are 0.
  - in_en=1 with in=1 goes to ON_P; in_en=1 with in=0 goes to ON_N.
  - The active counter is cleared on this transition.
- ON_P: drv_p=1, drv_en=1.
  - in_en=0 goes to DEAD, with exit to COOLDOWN.
  - in=0 goes to DEAD.
- ON_N: symmetric to ON_P; drv_n=1, and the phase change is triggered by in=1.
- DEAD: drv_p=drv_n=0, drv_en=1, held for exactly DEAD_CYCLES cycles. At expiry, the inputs are re-evaluated:
  - in_en=0 goes to COOLDOWN.
  - Otherwise, go to ON_P if in=1, else ON_N. This applies even if in returned to the previous phase during DEAD.
- in_en falling in any ON state always passes through DEAD before drv_en drops.
- Active counter: increments every cycle in ON_P, ON_N or DEAD. If it reaches MAX_ACTIVE_CYCLES while in_en=1:
  - go to FAULT;
  - drives and drv_en drop on the next edge, with no dead-time wait (all off is safe);
  - fault=1.
  - Consequence: drv_en is never high for more than MAX_ACTIVE_CYCLES consecutive cycles.
- FAULT: all drives are 0 and fault=1. Exit to COOLDOWN only when fault_clear=1 and in_en=0 on the same cycle; fault returns to 0 on that exit edge.
- COOLDOWN: all drives are 0 for exactly MIN_IDLE_CYCLES cycles, then IDLE. in_en is ignored here.
- burst_dropped: pulses for 1 cycle on a rising edge of in_en (registered previous in_en=0, current=1) seen in COOLDOWN or FAULT. A burst already high when COOLDOWN ends is accepted on the first IDLE cycle.
- Invariants:
  - drv_p & drv_n is never 1.
  - After either drive falls, both stay low for at least DEAD_CYCLES cycles before either rises.
  - drv_p | drv_n implies drv_en.
- Counter widths: $clog2(param+1). No wrap is possible, because each counter stops at its terminal value.

Test Plan:
1. Nominal burst, defaults. Stimulus: in_en=1 for 96 cycles; in toggles every 3 cycles starting high. Required response:
   - drv_p high 1 cycle after in_en;
   - every phase is 2 cycles on, 1 cycle dead;
   - drv_p and drv_n never overlap;
   - drv_en falls 1 cycle after the final DEAD;
   - fault stays 0.
2. Over-length burst. Stimulus: in_en held high for 200 cycles. Required response:
   - drv_en high exactly 128 cycles;
   - then fault=1 with all drives 0;
   - asserting fault_clear with in_en still 1 has no effect;
   - after in_en=0 and fault_clear=1, fault drops, followed by 81 cycles of COOLDOWN and then IDLE.
3. Back-to-back bursts. Stimulus: burst A ends, and burst B's in_en rises 40 cycles later. Required response:
   - burst_dropped=1 for 1 cycle;
   - no drive activity for burst B during COOLDOWN;
   - if B's in_en is still high when COOLDOWN ends, B drives from the first IDLE cycle.
4. Glitch in DEAD. Stimulus: with DEAD_CYCLES=2, in goes 1→0→1 inside DEAD. Required response: the drive resumes drv_p after exactly 2 dead cycles, with no drv_n pulse.
5. Reset mid-burst. Stimulus: n_reset=0 during ON_N. Required response:
   - drv_n, drv_en and fault are all 0 on the next edge;
   - after release, a new in_en starts a burst from IDLE with no cooldown.
6. Single-cycle burst. Stimulus: in_en=1 for 1 cycle with in=0. Required response: drv_n=1 for 1 cycle, then 1 DEAD cycle, then 81 COOLDOWN cycles.
